// File: rtl/shift_requant_pipe_pkg.sv
// Shared constants and helpers for the shift/requantise pipeline.
package shift_requant_pipe_pkg;

    function automatic longint out_max_s(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint out_min_s(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    function automatic longint out_max_u(input int w);
        return (longint'(1) <<< w) - 1;
    endfunction

    // Bit offset of a lane inside a packed multi-lane bus.
    function automatic int lane_lsb(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/shift_requant_lane.sv
// Combinational per-lane logic: S1 shift (plus round bit) and S2 round/clamp.
// Rounding is present only when SHIFT_ROUND_EN is defined.
module shift_requant_lane
    import shift_requant_pipe_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 5
) (
    input  logic [IN_W-1:0]    x,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               signext,
    output logic signed [IN_W:0] sh,
`ifdef SHIFT_ROUND_EN
    output logic               rbit,
    input  logic               rbit_q,
`endif
    input  logic signed [IN_W:0] sh_q,
    input  logic               signext_q,
    output logic [OUT_W-1:0]   q,
    output logic               sat
);

    localparam longint MAX_S = out_max_s(OUT_W);
    localparam longint MIN_S = out_min_s(OUT_W);
    localparam longint MAX_U = out_max_u(OUT_W);

    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] v;
    logic signed [63:0]   v64;

    // One extra bit keeps unsigned words positive under the arithmetic shift.
    always_comb begin
        ext = {signext & x[IN_W-1], x};
        sh  = ext >>> shift;
    end

`ifdef SHIFT_ROUND_EN
    always_comb begin
        rbit = 1'b0;
        for (int k = 0; k < IN_W; k++) begin
            if (int'(shift) == k + 1) rbit = x[k];
        end
    end

    assign v = sh_q + {{IN_W{1'b0}}, rbit_q};
`else
    assign v = sh_q;
`endif

    assign v64 = {{(63 - IN_W){v[IN_W]}}, v};

    always_comb begin
        q   = v[OUT_W-1:0];
        sat = 1'b0;
        if (signext_q) begin
            if (v64 > MAX_S) begin
                q   = OUT_W'(MAX_S);
                sat = 1'b1;
            end else if (v64 < MIN_S) begin
                q   = OUT_W'(MIN_S);
                sat = 1'b1;
            end
        end else if (v64 > MAX_U) begin
            q   = OUT_W'(MAX_U);
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/shift_requant_pipe.sv
// Two-stage multi-lane requantiser (S1 shift, S2 round+saturate) with valid/ready.
// Optional round-half-up enabled by SHIFT_ROUND_EN.
module shift_requant_pipe
    import shift_requant_pipe_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int IN_W    = 32,
    parameter int OUT_W   = 8,
    parameter int SHIFT_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    input  logic [SHIFT_W-1:0]     in_shift,
    input  logic                   in_signext,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [LANES-1:0]       out_sat
);

    logic                 v1_reg;
    logic                 v2_reg;
    logic                 signext_reg;
    logic signed [IN_W:0] sh_reg  [LANES];
    logic signed [IN_W:0] sh_next [LANES];
    logic [OUT_W-1:0]     q_next  [LANES];
    logic [LANES-1:0]     sat_next;
`ifdef SHIFT_ROUND_EN
    logic [LANES-1:0]     rbit_reg;
    logic [LANES-1:0]     rbit_next;
`endif
    logic                 load1;
    logic                 load2;

    // S2 frees up when empty or draining this cycle, letting S1 advance too.
    assign in_ready  = !v1_reg || !v2_reg || out_ready;
    assign load1     = in_valid && in_ready;
    assign load2     = v1_reg && (!v2_reg || out_ready);
    assign out_valid = v2_reg;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            shift_requant_lane #(
                .IN_W    (IN_W),
                .OUT_W   (OUT_W),
                .SHIFT_W (SHIFT_W)
            ) u_lane (
                .x         (in_data[lane_lsb(gi, IN_W) +: IN_W]),
                .shift     (in_shift),
                .signext   (in_signext),
                .sh        (sh_next[gi]),
`ifdef SHIFT_ROUND_EN
                .rbit      (rbit_next[gi]),
                .rbit_q    (rbit_reg[gi]),
`endif
                .sh_q      (sh_reg[gi]),
                .signext_q (signext_reg),
                .q         (q_next[gi]),
                .sat       (sat_next[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg      <= 1'b0;
            v2_reg      <= 1'b0;
            signext_reg <= 1'b0;
            out_data    <= '0;
            out_sat     <= '0;
            for (int i = 0; i < LANES; i++) sh_reg[i] <= '0;
`ifdef SHIFT_ROUND_EN
            rbit_reg    <= '0;
`endif
        end else begin
            if (load1)      v1_reg <= 1'b1;
            else if (load2) v1_reg <= 1'b0;

            if (load2)          v2_reg <= 1'b1;
            else if (out_ready) v2_reg <= 1'b0;

            if (load1) begin
                signext_reg <= in_signext;
                for (int i = 0; i < LANES; i++) sh_reg[i] <= sh_next[i];
`ifdef SHIFT_ROUND_EN
                rbit_reg <= rbit_next;
`endif
            end

            if (load2) begin
                for (int i = 0; i < LANES; i++)
                    out_data[lane_lsb(i, OUT_W) +: OUT_W] <= q_next[i];
                out_sat <= sat_next;
            end
        end
    end

endmodule
